// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: frame constants, TX state encoding and parity.
package uart_pkg;

    localparam int unsigned DATA_BITS         = 7;
    localparam int unsigned IDX_W             = $clog2(DATA_BITS);
    localparam logic        START_SIG_DEFAULT = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        PARITY = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Even parity is the XOR of the data; odd parity is its complement.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner search from pointer+1 upward, registered pointer.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;

    // Pointer starts at the last requester so requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            ptr <= ID_W'(N_REQ - 1);
        end else if (en) begin
            ptr <= winner;
        end
    end

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one serial TX line between N_REQ requesters; frames are start, parity, 7 data bits LSB first,
// stop, followed by at least one idle cycle.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int unsigned N_REQ      = 4,
    parameter  logic        START_SIG  = START_SIG_DEFAULT,
    parameter  logic        ODD_PARITY = 1'b0,
    localparam int unsigned ID_W       = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [N_REQ-1:0]           req,
    input  logic [DATA_BITS*N_REQ-1:0] data_in,
    output logic [N_REQ-1:0]           ack,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy,
    output logic                       done,
    output logic                       s_out
);

    tx_state_e             state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic                  grant;
    logic [ID_W-1:0]       arb_winner;
    logic                  arb_valid;
    logic [DATA_BITS-1:0]  data_q;
    logic                  parity_q;
    logic [DATA_BITS-1:0]  words [N_REQ];

    logic [N_REQ-1:0]      ack_nxt;
    logic [ID_W-1:0]       grant_id_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic                  s_out_nxt;

    for (genvar i = 0; i < N_REQ; i++) begin : g_words
        assign words[i] = data_in[DATA_BITS*i +: DATA_BITS];
    end

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk    (clk),
        .rstN   (rstN),
        .req    (req),
        .en     (grant),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next state: requests are only looked at in IDLE, so every frame is followed by an idle cycle.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant     = 1'b1;
                    state_nxt = START;
                end
            end
            START:  state_nxt = PARITY;
            PARITY: begin
                state_nxt = DATA;
                idx_nxt   = '0;
            end
            DATA: begin
                if (idx == IDX_W'(DATA_BITS - 1)) begin
                    state_nxt = STOP;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs for the upcoming state, registered alongside it so s_out tracks the current state.
    always_comb begin
        s_out_nxt    = ~START_SIG;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        ack_nxt      = '0;
        grant_id_nxt = grant_id;
        if (grant) begin
            ack_nxt[arb_winner] = 1'b1;
            grant_id_nxt        = arb_winner;
        end
        case (state_nxt)
            START: begin
                s_out_nxt = START_SIG;
                busy_nxt  = 1'b1;
            end
            PARITY: begin
                s_out_nxt = parity_q;
                busy_nxt  = 1'b1;
            end
            DATA: begin
                s_out_nxt = data_q[idx_nxt];
                busy_nxt  = 1'b1;
            end
            STOP: begin
                s_out_nxt = ~START_SIG;
                busy_nxt  = 1'b1;
                done_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    // Word and parity are captured once at the grant edge; later data_in changes are ignored.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            data_q   <= '0;
            parity_q <= 1'b0;
        end else if (grant) begin
            data_q   <= words[arb_winner];
            parity_q <= parity_bit(words[arb_winner], ODD_PARITY);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            s_out    <= ~START_SIG;
            ack      <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            s_out    <= s_out_nxt;
            ack      <= ack_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
            grant_id <= grant_id_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized requests against a
// frame-level round-robin model.
module tb_uart_tx_scheduler;

    localparam int N = 4;

    logic         clk    = 1'b0;
    logic         rstN   = 1'b0;
    logic [N-1:0] req_e  = '0;
    logic [N-1:0] req_o  = '0;
    logic [7*N-1:0] data_e = '0;
    logic [7*N-1:0] data_o = '0;
    logic [N-1:0] ack_e, ack_o;
    logic [1:0]   gid_e, gid_o;
    logic         busy_e, busy_o, done_e, done_o, s_e, s_o;

    bit           use_odd = 1'b0;
    logic [N-1:0] o_ack;
    logic [1:0]   o_gid;
    logic         o_busy, o_done, o_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_ptr = N - 1;

    uart_tx_scheduler #(.N_REQ(4), .START_SIG(1'b0), .ODD_PARITY(1'b0)) dut (
        .clk(clk), .rstN(rstN), .req(req_e), .data_in(data_e),
        .ack(ack_e), .grant_id(gid_e), .busy(busy_e), .done(done_e), .s_out(s_e)
    );

    uart_tx_scheduler #(.N_REQ(4), .START_SIG(1'b0), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rstN(rstN), .req(req_o), .data_in(data_o),
        .ack(ack_o), .grant_id(gid_o), .busy(busy_o), .done(done_o), .s_out(s_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign o_ack  = use_odd ? ack_o  : ack_e;
    assign o_gid  = use_odd ? gid_o  : gid_e;
    assign o_busy = use_odd ? busy_o : busy_e;
    assign o_done = use_odd ? done_o : done_e;
    assign o_s    = use_odd ? s_o    : s_e;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester set scanning upward from last winner + 1, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] cur_req();
        return use_odd ? req_o : req_e;
    endfunction

    function automatic logic [6:0] get_word(input int i);
        return use_odd ? data_o[7*i +: 7] : data_e[7*i +: 7];
    endfunction

    task automatic set_word(input int i, input logic [6:0] v);
        if (use_odd) data_o[7*i +: 7] = v;
        else         data_e[7*i +: 7] = v;
    endtask

    task automatic req_or(input logic [N-1:0] m);
        if (use_odd) req_o = req_o | m;
        else         req_e = req_e | m;
    endtask

    task automatic req_andn(input logic [N-1:0] m);
        if (use_odd) req_o = req_o & ~m;
        else         req_e = req_e & ~m;
    endtask

    task automatic wait_ack(input int limit, output int at);
        int n;
        n = 0;
        while (o_ack === '0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (|o_ack === 1'b1) else begin
            bad++;
            $error("FAIL ack_timeout observed=%0h expected=nonzero", o_ack);
        end
        at = cyc;
    endtask

    task automatic idle_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_ack", 32'(o_ack), 32'(0));
            chk("idle_busy", 32'(o_busy), 32'(0));
            chk("idle_s_out", 32'(o_s), 32'(1));
        end
    endtask

    // Called in the START cycle; walks the whole frame and ends in the following idle cycle.
    task automatic expect_frame(input int g, input logic [6:0] d, input bit keep,
                                input logic [N-1:0] set_m, input logic [N-1:0] clr_m);
        logic par;
        logic exp_s;
        par = (^d) ^ use_odd;
        chk("ack_onehot", 32'(o_ack), 32'(1 << g));
        chk("grant_id", 32'(o_gid), 32'(g));
        chk("busy_start", 32'(o_busy), 32'(1));
        chk("done_start", 32'(o_done), 32'(0));
        chk("s_out_start", 32'(o_s), 32'(0));
        if (!keep) req_andn(N'(1 << g));
        set_word(g, 7'($urandom));
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (c == 3) req_or(set_m);
            if (c == 4) req_andn(clr_m);
            if (c == 1)      exp_s = par;
            else if (c <= 8) exp_s = d[c-2];
            else             exp_s = 1'b1;
            chk("s_out_bit", 32'(o_s), 32'(exp_s));
            chk("ack_quiet", 32'(o_ack), 32'(0));
            chk("done", 32'(o_done), 32'(c == 9));
            chk("busy", 32'(o_busy), 32'(1));
        end
        @(negedge clk);
        chk("s_out_guard", 32'(o_s), 32'(1));
        chk("busy_guard", 32'(o_busy), 32'(0));
        chk("done_guard", 32'(o_done), 32'(0));
        chk("grant_id_hold", 32'(o_gid), 32'(g));
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        m_ptr = N - 1;
    endtask

    initial begin
        int g, at, last, c0;
        logic [N-1:0] newr;
        logic [6:0] d;

        repeat (3) @(negedge clk);
        chk("rst_s_out", 32'(s_e), 32'(1));
        chk("rst_ack", 32'(ack_e), 32'(0));
        chk("rst_busy", 32'(busy_e), 32'(0));
        chk("rst_done", 32'(done_e), 32'(0));
        chk("rst_grant_id", 32'(gid_e), 32'(0));
        chk("rst_s_out_odd", 32'(s_o), 32'(1));
        rstN = 1'b1;
        @(negedge clk);

        // Single request, 7'h55 even parity.
        set_word(0, 7'h55);
        c0 = cyc;
        req_or(N'(4'b0001));
        g = rr_pick(cur_req(), m_ptr);
        d = get_word(g);
        wait_ack(20, at);
        chk("ack_latency", 32'(at - c0), 32'(1));
        expect_frame(g, d, 1'b0, '0, '0);
        m_ptr = g;
        idle_quiet(4);

        // All four requesting from reset: grants 0,1,2,3 exactly 11 cycles apart.
        do_reset();
        set_word(0, 7'h01); set_word(1, 7'h02); set_word(2, 7'h04); set_word(3, 7'h08);
        req_or(N'(4'b1111));
        last = 0;
        for (int k = 0; k < 4; k++) begin
            g = rr_pick(cur_req(), m_ptr);
            d = get_word(g);
            wait_ack(20, at);
            if (k > 0) chk("spacing_all4", 32'(at - last), 32'(11));
            last = at;
            expect_frame(g, d, 1'b0, '0, '0);
            m_ptr = g;
        end

        // Fairness: requester 2 held permanently, requester 0 arrives mid-frame.
        set_word(2, 7'h3C);
        req_or(N'(4'b0100));
        g = rr_pick(cur_req(), m_ptr);
        d = get_word(g);
        wait_ack(20, at);
        last = at;
        expect_frame(g, d, 1'b1, N'(4'b0001), '0);
        m_ptr = g;
        g = rr_pick(cur_req(), m_ptr);
        d = get_word(g);
        wait_ack(20, at);
        chk("spacing_fair", 32'(at - last), 32'(11));
        last = at;
        expect_frame(g, d, 1'b0, '0, '0);
        m_ptr = g;
        g = rr_pick(cur_req(), m_ptr);
        d = get_word(g);
        wait_ack(20, at);
        chk("spacing_fair2", 32'(at - last), 32'(11));
        expect_frame(g, d, 1'b0, '0, '0);
        m_ptr = g;

        // Reset while DATA index 3 is on the line.
        set_word(0, 7'h5A);
        req_or(N'(4'b0001));
        d = get_word(0);
        wait_ack(20, at);
        req_andn(N'(4'b0001));
        repeat (5) @(negedge clk);
        chk("s_out_data3", 32'(o_s), 32'(d[3]));
        rstN = 1'b0;
        @(negedge clk);
        chk("midrst_s_out", 32'(o_s), 32'(1));
        chk("midrst_busy", 32'(o_busy), 32'(0));
        chk("midrst_ack", 32'(o_ack), 32'(0));
        chk("midrst_done", 32'(o_done), 32'(0));
        chk("midrst_grant_id", 32'(o_gid), 32'(0));
        rstN = 1'b1;
        m_ptr = N - 1;
        for (int i = 0; i < N; i++) set_word(i, 7'($urandom));
        req_or(N'(4'b1111));
        g = rr_pick(cur_req(), m_ptr);
        d = get_word(g);
        wait_ack(20, at);
        expect_frame(g, d, 1'b0, '0, '0);
        m_ptr = g;
        req_andn(N'(4'b1111));

        // Request 1 pulsed for one cycle mid-frame is withdrawn.
        set_word(0, 7'h33);
        req_or(N'(4'b0001));
        g = rr_pick(cur_req(), m_ptr);
        d = get_word(g);
        wait_ack(20, at);
        expect_frame(g, d, 1'b0, N'(4'b0010), N'(4'b0010));
        m_ptr = g;
        idle_quiet(5);

        // Odd parity instance.
        use_odd = 1'b1;
        set_word(0, 7'h7F);
        req_or(N'(4'b0001));
        wait_ack(20, at);
        expect_frame(0, 7'h7F, 1'b0, '0, '0);
        set_word(0, 7'h00);
        req_or(N'(4'b0001));
        wait_ack(20, at);
        expect_frame(0, 7'h00, 1'b0, '0, '0);
        use_odd = 1'b0;

        // Randomized back-to-back traffic.
        last = 0;
        for (int f = 0; f < 25; f++) begin
            newr = N'($urandom) & ~req_e;
            if ((req_e | newr) == '0) newr = N'(1 << $urandom_range(0, N - 1));
            for (int i = 0; i < N; i++) if (newr[i]) set_word(i, 7'($urandom));
            req_or(newr);
            g = rr_pick(cur_req(), m_ptr);
            d = get_word(g);
            wait_ack(20, at);
            if (f > 0) chk("spacing_rand", 32'(at - last), 32'(11));
            last = at;
            expect_frame(g, d, 1'b0, '0, '0);
            m_ptr = g;
        end
        req_andn(N'(4'b1111));
        idle_quiet(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
